cr_prefix_pf_sched: RTL and testbench

//  Schedules prefix-number results from N_REQ prefix-detect engines into the shared 9-bit pf FIFO.
//  The OBC pops that FIFO in frame order. Frames are dispatched to engines round-robin, so in
//  in-order mode results are re-sequenced strictly by engine index. Engines that miss their slot
//  get a timeout error entry in their place.

---
 rtl/cr_prefix_pf_sched.sv | 132 +++++++++++++
 tb/tb_cr_prefix_pf_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_prefix_pf_sched.sv
// cr_prefix_pf_sched
//   Merges prefix-number results from N_REQ prefix-detect engines into the
//   shared 9-bit pf FIFO. In in-order mode results are written strictly by
//   engine index; an engine that stays silent for cfg_timeout cycles gets an
//   error entry in its slot and its late result is discarded when it shows up.
//   In round-robin mode the next valid engine at or after sched_ptr wins.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cfg_in_order    1 = strict engine order, 0 = round-robin
//   cfg_timeout     in-order slot timeout in cycles, 0 disables it
//   req_valid/data  per-engine result {err, code[7:0]}, 9 bits per engine
//   req_ready       per-engine consume strobe (combinational)
//   pf_full/afull   FIFO back-pressure
//   pf_wr/pf_wdata  registered FIFO write port
//   sched_ptr       engine expected (in-order) or favoured (round-robin) next
//   timeout_event   one-cycle pulse when a timeout entry is written
//   drop_event      one-cycle pulse when a late result is discarded
module cr_prefix_pf_sched #(
    parameter int         N_REQ       = 4,
    parameter int         TO_W        = 16,
    parameter logic [7:0] TO_ERR_CODE = 8'h2F
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_in_order,
    input  logic [TO_W-1:0]          cfg_timeout,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [9*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     pf_full,
    input  logic                     pf_afull,
    output logic                     pf_wr,
    output logic [8:0]               pf_wdata,
    output logic [$clog2(N_REQ)-1:0] sched_ptr,
    output logic                     timeout_event,
    output logic                     drop_event
);

    localparam int PTR_W = $clog2(N_REQ);

    logic             stall;
    logic [N_REQ-1:0] skip;
    logic [N_REQ-1:0] drop;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;
    logic [TO_W-1:0]  timer;
    logic             to_count;
    logic             to_fire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
    endfunction

    // Stage p0: arbitration, drop detection and timeout expiry
    always_comb begin
        // A write already in flight while almost-full would overrun the FIFO.
        stall     = pf_full | (pf_afull & pf_wr);
        drop      = skip & req_valid;
        elig      = req_valid & ~skip;
        grant_any = 1'b0;
        grant_idx = sched_ptr;
        cand      = '0;
        if (cfg_in_order) begin
            grant_any = elig[sched_ptr];
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = PTR_W'((int'(sched_ptr) + k) % N_REQ);
                if (!grant_any && elig[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant_any = grant_any & ~stall;
        grant     = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
        req_ready = grant | drop;

        // A valid result on the expiry cycle means no count, so the grant wins.
        to_count = cfg_in_order & (cfg_timeout != '0) & ~req_valid[sched_ptr] & ~stall;
        to_fire  = to_count & (timer == cfg_timeout - TO_W'(1));
    end

    // Stage p1: registered FIFO write, scheduler state and event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_wr         <= 1'b0;
            pf_wdata      <= '0;
            sched_ptr     <= '0;
            timer         <= '0;
            skip          <= '0;
            timeout_event <= 1'b0;
            drop_event    <= 1'b0;
        end else begin
            pf_wr         <= grant_any | to_fire;
            timeout_event <= to_fire;
            drop_event    <= |drop;

            if (grant_any)
                pf_wdata <= req_data[9*grant_idx +: 9];
            else if (to_fire)
                pf_wdata <= {1'b1, TO_ERR_CODE};

            // to_fire needs ~req_valid[sched_ptr], so it never collides with a drop of that engine.
            for (int i = 0; i < N_REQ; i++) begin
                if (to_fire && (PTR_W'(i) == sched_ptr))
                    skip[i] <= 1'b1;
                else if (drop[i])
                    skip[i] <= 1'b0;
            end

            if (grant_any)
                sched_ptr <= next_ptr(grant_idx);
            else if (to_fire)
                sched_ptr <= next_ptr(sched_ptr);

            if (!cfg_in_order || grant_any || to_fire)
                timer <= '0;
            else if (to_count)
                timer <= sat_inc(timer);
        end
    end

endmodule

// File: tb/tb_cr_prefix_pf_sched.sv
module tb_cr_prefix_pf_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_in_order;
    logic [15:0] cfg_timeout;
    logic [3:0]  req_valid;
    logic [35:0] req_data;
    logic [3:0]  req_ready;
    logic        pf_full;
    logic        pf_afull;
    logic        pf_wr;
    logic [8:0]  pf_wdata;
    logic [1:0]  sched_ptr;
    logic        timeout_event;
    logic        drop_event;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] rdy_s;
    logic [3:0] vld_s;
    logic [8:0] wq[$];

    cr_prefix_pf_sched #(.N_REQ(4), .TO_W(16), .TO_ERR_CODE(8'h2F)) dut (
        .clk(clk), .rst(rst), .cfg_in_order(cfg_in_order), .cfg_timeout(cfg_timeout),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pf_full(pf_full), .pf_afull(pf_afull), .pf_wr(pf_wr), .pf_wdata(pf_wdata),
        .sched_ptr(sched_ptr), .timeout_event(timeout_event), .drop_event(drop_event)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: sample handshake mid-cycle, advance, retire consumed results, log writes.
    task automatic cycle();
        #2;
        rdy_s = req_ready;
        vld_s = req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(vld_s & rdy_s);
        if (pf_wr) wq.push_back(pf_wdata);
    endtask

    task automatic set_eng(input int i, input logic [8:0] d);
        req_data[9*i +: 9] = d;
        req_valid[i]       = 1'b1;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        pf_full   = 1'b0;
        pf_afull  = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (pf_wr !== 1'b0) begin n_err++; $display("FAIL reset_pf_wr: got %b want 0", pf_wr); end
        n_cmp++; if (pf_wdata !== 9'h000) begin n_err++; $display("FAIL reset_pf_wdata: got %h want 000", pf_wdata); end
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (sched_ptr !== 2'd0) begin n_err++; $display("FAIL reset_sched_ptr: got %0d want 0", sched_ptr); end
        n_cmp++; if (timeout_event !== 1'b0) begin n_err++; $display("FAIL reset_timeout_event: got %b want 0", timeout_event); end
        n_cmp++; if (drop_event !== 1'b0) begin n_err++; $display("FAIL reset_drop_event: got %b want 0", drop_event); end
        rst = 1'b0;
    endtask

    task automatic test_in_order_sequence();
        int start_cyc[4];
        start_cyc = '{1, 3, 0, 2};
        cfg_in_order = 1'b1;
        cfg_timeout  = '0;
        wq.delete();
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 4; i++)
                if (t == start_cyc[i]) set_eng(i, 9'h005 + 9'(i));
            cycle();
        end
        n_cmp++; if (wq.size() != 4) begin n_err++; $display("FAIL inorder_count: got %0d want 4", wq.size()); end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            n_cmp++;
            if (wq[k] !== 9'h005 + 9'(k)) begin n_err++; $display("FAIL inorder_data[%0d]: got %h want %h", k, wq[k], 9'h005 + 9'(k)); end
        end
        n_cmp++; if (sched_ptr !== 2'd0) begin n_err++; $display("FAIL inorder_ptr_wrap: got %0d want 0", sched_ptr); end
    endtask

    task automatic test_rr_back_to_back();
        cfg_in_order = 1'b0;
        for (int i = 0; i < 4; i++) set_eng(i, 9'h010 + 9'(i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            req_valid = 4'hF;
            n_cmp++; if (pf_wr !== 1'b1) begin n_err++; $display("FAIL rr_wr[%0d]: got %b want 1", k, pf_wr); end
            n_cmp++;
            if (pf_wdata !== 9'h010 + 9'(k % 4)) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, pf_wdata, 9'h010 + 9'(k % 4)); end
        end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_afull_stall();
        req_valid = 4'hF;
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || pf_wdata !== 9'h011) begin n_err++; $display("FAIL afull_pre: got wr=%b data=%h want wr=1 data=011", pf_wr, pf_wdata); end
        req_valid = 4'hF;
        pf_afull  = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL afull_ready: got %b want 0000", req_ready); end
        cycle();
        n_cmp++; if (pf_wr !== 1'b0) begin n_err++; $display("FAIL afull_wr_low: got %b want 0", pf_wr); end
        pf_afull  = 1'b0;
        req_valid = 4'hF;
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || pf_wdata !== 9'h012) begin n_err++; $display("FAIL afull_resume: got wr=%b data=%h want wr=1 data=012", pf_wr, pf_wdata); end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_timeout();
        int bad;
        reset_dut();
        cfg_in_order = 1'b1;
        cfg_timeout  = 16'd10;
        set_eng(0, 9'h021);
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || pf_wdata !== 9'h021) begin n_err++; $display("FAIL to_grant0: got wr=%b data=%h want wr=1 data=021", pf_wr, pf_wdata); end
        bad = 0;
        for (int n = 1; n < 10; n++) begin
            cycle();
            if (pf_wr || timeout_event) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL to_early: got %0d early writes want 0", bad); end
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || pf_wdata !== 9'h12F) begin n_err++; $display("FAIL to_entry: got wr=%b data=%h want wr=1 data=12f", pf_wr, pf_wdata); end
        n_cmp++; if (timeout_event !== 1'b1) begin n_err++; $display("FAIL to_event: got %b want 1", timeout_event); end
        n_cmp++; if (sched_ptr !== 2'd2) begin n_err++; $display("FAIL to_ptr: got %0d want 2", sched_ptr); end
        set_eng(1, 9'h031);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL drop_ready: got %b want 0010", req_ready); end
        cycle();
        n_cmp++; if (drop_event !== 1'b1 || pf_wr !== 1'b0) begin n_err++; $display("FAIL drop_pulse: got ev=%b wr=%b want ev=1 wr=0", drop_event, pf_wr); end
        cycle();
        n_cmp++; if (drop_event !== 1'b0) begin n_err++; $display("FAIL drop_once: got %b want 0", drop_event); end
    endtask

    task automatic test_expiry_race();
        reset_dut();
        cfg_in_order = 1'b1;
        cfg_timeout  = 16'd10;
        set_eng(0, 9'h021);
        cycle();
        for (int n = 1; n < 10; n++) cycle();
        set_eng(1, 9'h041);
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || pf_wdata !== 9'h041) begin n_err++; $display("FAIL race_data: got wr=%b data=%h want wr=1 data=041", pf_wr, pf_wdata); end
        n_cmp++; if (timeout_event !== 1'b0) begin n_err++; $display("FAIL race_no_timeout: got %b want 0", timeout_event); end
        n_cmp++; if (sched_ptr !== 2'd2) begin n_err++; $display("FAIL race_ptr: got %0d want 2", sched_ptr); end
        set_eng(2, 9'h042);
        set_eng(3, 9'h043);
        set_eng(0, 9'h044);
        repeat (3) cycle();
        set_eng(1, 9'h045);
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || pf_wdata !== 9'h045 || drop_event !== 1'b0) begin
            n_err++; $display("FAIL race_skip_clear: got wr=%b data=%h drop=%b want wr=1 data=045 drop=0", pf_wr, pf_wdata, drop_event);
        end
    endtask

    task automatic test_async_reset();
        int first;
        logic [8:0] first_data;
        reset_dut();
        cfg_in_order = 1'b1;
        cfg_timeout  = '0;
        set_eng(0, 9'h051);
        cycle();
        n_cmp++; if (pf_wr !== 1'b1 || sched_ptr !== 2'd1) begin n_err++; $display("FAIL arst_pre: got wr=%b ptr=%0d want wr=1 ptr=1", pf_wr, sched_ptr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (pf_wr !== 1'b0 || sched_ptr !== 2'd0 || pf_wdata !== 9'h000) begin
            n_err++; $display("FAIL arst_immediate: got wr=%b ptr=%0d data=%h want wr=0 ptr=0 data=000", pf_wr, sched_ptr, pf_wdata);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        cfg_timeout = 16'd20;
        set_eng(0, 9'h052);
        cycle();
        repeat (7) cycle();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sched_ptr !== 2'd0 || pf_wr !== 1'b0) begin n_err++; $display("FAIL arst_timer_state: got ptr=%0d wr=%b want ptr=0 wr=0", sched_ptr, pf_wr); end
        #1 rst = 1'b0;
        cfg_timeout = 16'd10;
        first = -1;
        first_data = '0;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (first < 0 && pf_wr) begin first = n; first_data = pf_wdata; end
        end
        n_cmp++; if (first != 10) begin n_err++; $display("FAIL arst_timer_clear: got first timeout at cycle %0d want 10", first); end
        n_cmp++; if (first_data !== 9'h12F) begin n_err++; $display("FAIL arst_timeout_data: got %h want 12f", first_data); end
    endtask

    // Random engine traffic and FIFO-full back-pressure against a slot-level model.
    task automatic test_random(input logic in_order);
        int         pend[4];
        int         dly[4];
        int         mptr;
        int         g;
        int         budget;
        logic [3:0] exp_rdy;
        logic [3:0] vb;
        logic [8:0] exp_q[$];
        reset_dut();
        cfg_in_order = in_order;
        cfg_timeout  = '0;
        for (int i = 0; i < 4; i++) begin pend[i] = 0; dly[i] = $urandom_range(0, 3); end
        mptr   = 0;
        budget = 0;
        while ((pend[0] < 8 || pend[1] < 8 || pend[2] < 8 || pend[3] < 8) && budget < 2000) begin
            budget++;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && pend[i] < 8) begin
                    if (dly[i] == 0) set_eng(i, {1'b0, 3'(i), 5'(pend[i])});
                    else dly[i]--;
                end
            end
            pf_full = ($urandom_range(0, 3) == 0);
            #1;
            g = -1;
            if (!pf_full) begin
                if (in_order) begin
                    if (req_valid[mptr]) g = mptr;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (g < 0 && req_valid[(mptr + k) % 4]) g = (mptr + k) % 4;
                end
            end
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rand%0d_ready: got %b want %b", in_order, req_ready, exp_rdy); end
            if (g >= 0) exp_q.push_back(req_data[9*g +: 9]);
            vb = req_valid;
            cycle();
            for (int i = 0; i < 4; i++)
                if (vb[i] && rdy_s[i]) begin pend[i]++; dly[i] = $urandom_range(0, 3); end
            if (g >= 0) mptr = (g + 1) % 4;
            n_cmp++; if (sched_ptr !== 2'(mptr)) begin n_err++; $display("FAIL rand%0d_ptr: got %0d want %0d", in_order, sched_ptr, mptr); end
        end
        pf_full = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (budget >= 2000) begin n_err++; $display("FAIL rand%0d_budget: got %0d cycles want < 2000", in_order, budget); end
        n_cmp++; if (wq.size() != 32 || exp_q.size() != 32) begin n_err++; $display("FAIL rand%0d_count: got %0d writes want 32", in_order, wq.size()); end
        for (int k = 0; k < wq.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (wq[k] !== exp_q[k]) begin n_err++; $display("FAIL rand%0d_data[%0d]: got %h want %h", in_order, k, wq[k], exp_q[k]); end
        end
    endtask

    initial begin
        rst          = 1'b1;
        cfg_in_order = 1'b0;
        cfg_timeout  = '0;
        req_valid    = '0;
        req_data     = '0;
        pf_full      = 1'b0;
        pf_afull     = 1'b0;
        test_reset();
        test_in_order_sequence();
        test_rr_back_to_back();
        test_afull_stall();
        test_timeout();
        test_expiry_race();
        test_async_reset();
        test_random(1'b1);
        test_random(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
